control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, the width of the AR and PC address fields.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the width of IR, DR, AC and memory words.
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port clear  input  1  synchronous, active-high reset.
REQ-005 SHALL have port run  input  1  when high, permits a new instruction to start at T0.
REQ-006 SHALL have port ir_data  input  DATA_WIDTH  IR register output; bit 15 is I, bits 14:12 are opcode, bits 11:0 are address or register-ref bits.
REQ-007 SHALL have port dr_zero  input  1  high when the DR register output equals 0.
REQ-008 SHALL have outputs ar_load/ar_inc/ar_clr, pc_load/pc_inc/pc_clr, dr_load/dr_inc, ac_load/ac_inc/ac_clr, ir_load  output  1 each  enable_write/increment/clear strobes for the datapath Register instances.
REQ-009 SHALL have port mem_write  output  1  memory write strobe at address AR.
REQ-010 SHALL have port bus_sel  output  3  common-bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 memory.
REQ-011 SHALL have port alu_op  output  3  AC input function: 0 none, 1 AND, 2 ADD, 3 pass DR, 4 complement AC.
REQ-012 SHALL have port sc_value  output  4  current sequence count; and port halted  output  1  high while in HALT.

Function
REQ-013 SHALL hold a 4-bit sequence counter SC; all strobes SHALL be combinational decodes of SC, latched opcode/I and halted, valid during the cycle, taking effect at the ending edge.
REQ-014 SHALL assert at most one of load/inc/clr per register per cycle.
REQ-015 SHALL, at T0 with run=1, drive bus_sel=2 and ar_load, then advance SC; with run=0, SHALL hold SC=0 and assert no strobe.
REQ-016 SHALL, at T1, drive bus_sel=7, ir_load and pc_inc.
REQ-017 SHALL, at T2, drive bus_sel=5 and ar_load, and latch ir_data[15:12] at the T2 edge.
REQ-018 SHALL, at T3 for memory-reference (opcode != 7), drive bus_sel=7 and ar_load if I=1; if I=0, SHALL assert no strobe.
REQ-019 SHALL execute AND/ADD/LDA (opcode 0/1/2) as T4: bus_sel=7, dr_load; T5: ac_load with alu_op 1/2/3; then SC<=0.
REQ-020 SHALL execute STA (3) as T4: bus_sel=4, mem_write; SC<=0.
REQ-021 SHALL execute BUN (4) as T4: bus_sel=1, pc_load; SC<=0.
REQ-022 SHALL execute BSA (5) as T4: bus_sel=2, mem_write, ar_inc; T5: bus_sel=1, pc_load; SC<=0.
REQ-023 SHALL execute ISZ (6) as T4: bus_sel=7, dr_load; T5: dr_inc; T6: bus_sel=3, mem_write, plus pc_inc if dr_zero=1; SC<=0.
REQ-024 SHALL execute opcode 7 with I=0 at T3 using priority CLA (bit 11) > CMA (bit 9, ac_load with alu_op=4) > INC (bit 5, ac_inc) > HLT (bit 0), performing only the highest-priority set bit; SC<=0.
REQ-025 SHALL treat opcode 7 with I=1, or with none of those bits set, as a no-op at T3 with SC<=0.
REQ-026 SHALL, on HLT, set halted=1 at the T3 edge; while halted, SC SHALL stay 0, all strobes 0, and run SHALL be ignored.
REQ-027 SHALL never let SC exceed 6; reaching SC=15 is illegal and SHALL force SC<=0 with no strobes.

Reset
REQ-028 SHALL, on clear=1 at a rising edge, set SC=0, halted=0, and latched opcode/I=0, overriding any instruction in progress.
REQ-029 SHALL drive all strobes, bus_sel and alu_op to 0 during any cycle in which clear=1.

Structure
REQ-030 SHALL take the bus_sel codes, alu_op codes, opcode values and register-ref bit positions from a shared constants file, control_defs.
REQ-031 SHALL instantiate one sub-module, timing_decoder, mapping 4-bit SC to a 16-bit one-hot T vector.

Verification
REQ-032 SHALL verify: clear held 2 cycles, then run=1 -> sc_value=0 and halted=0 after the clear cycles, and SC=0 leads to bus_sel=2 with ar_load=1.
REQ-033 SHALL verify: LDA direct with ir_data=16'h2005 -> T1 ir_load+pc_inc; T2 ar_load, bus_sel=5; T3 no strobes; T4 dr_load; T5 ac_load, alu_op=3; next SC=0.
REQ-034 SHALL verify: ADD indirect with ir_data=16'h9010 -> T3 ar_load, bus_sel=7; T5 alu_op=2.
REQ-035 SHALL verify: ISZ with ir_data=16'h6020, dr_zero=1 at T6 -> mem_write, bus_sel=3, pc_inc=1; repeated with dr_zero=0 -> pc_inc=0.
REQ-036 SHALL verify: ir_data=16'h7801 (CLA+HLT) -> only ac_clr at T3, halted=0; ir_data=16'h7001 -> halted=1, SC frozen at 0 for 10 cycles, and a clear pulse resumes fetch.
REQ-037 SHALL verify: clear asserted during T4 of BSA -> no mem_write that cycle and SC=0 on the next cycle.

Source files
------------

// File: rtl/control_defs.sv
// Shared constants for the basic-computer control sequencer.
//   - common-bus source select codes
//   - AC input (ALU) function codes
//   - memory-reference / register-reference opcode values
//   - instruction field positions and register-reference bit positions
package control_defs;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_MEM  = 3'd7
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_AND  = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_DR   = 3'd3,
    ALU_CMA  = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_REG = 3'd7
  } opcode_e;

  // Instruction word fields
  localparam int IR_I_BIT  = 15;
  localparam int IR_OP_MSB = 14;
  localparam int IR_OP_LSB = 12;

  // Register-reference bits, listed from highest to lowest priority
  localparam int RR_CLA = 11;
  localparam int RR_CMA = 9;
  localparam int RR_INC = 5;
  localparam int RR_HLT = 0;

  localparam logic [3:0] SC_LAST = 4'd6;

endpackage

// File: rtl/timing_decoder.sv
// Sequence-count to timing-signal decoder.
//   sc : 4-bit sequence count
//   t  : 16-bit one-hot timing vector, t[n] high when sc == n
module timing_decoder
  import control_defs::*;
(
  input  logic [3:0]  sc,
  output logic [15:0] t
);

  assign t = 16'(1) << sc;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for a basic accumulator computer.
// A 4-bit sequence counter steps through fetch (T0..T2), effective-address
// resolution (T3) and execute (T4..T6). All datapath strobes are
// combinational decodes of the current timing signal, the latched opcode/I
// bit and the halted flag; they take effect at the edge that ends the cycle.
//
// Ports
//   clock, clear         : system clock, synchronous active-high reset
//   run                  : allows a new instruction to start at T0
//   ir_data              : IR contents (I, opcode, address/register-ref bits)
//   dr_zero              : DR currently holds zero
//   ar_*/pc_*/dr_*/ac_*  : load/increment/clear strobes of datapath registers
//   ir_load, mem_write   : IR load strobe, memory write strobe at AR
//   bus_sel, alu_op      : common-bus source and AC input function
//   sc_value, halted     : current sequence count, HLT executed
module control_sequencer
  import control_defs::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] ir_data,
  input  logic                  dr_zero,
  output logic                  ar_load,
  output logic                  ar_inc,
  output logic                  ar_clr,
  output logic                  pc_load,
  output logic                  pc_inc,
  output logic                  pc_clr,
  output logic                  dr_load,
  output logic                  dr_inc,
  output logic                  ac_load,
  output logic                  ac_inc,
  output logic                  ac_clr,
  output logic                  ir_load,
  output logic                  mem_write,
  output logic [2:0]            bus_sel,
  output logic [2:0]            alu_op,
  output logic [3:0]            sc_value,
  output logic                  halted
);

  logic [3:0]            sc;
  opcode_e               op_q;
  logic                  ind_q;
  logic                  halted_q;
  logic [15:0]           t;
  logic                  t_illegal;
  logic                  hlt_now;
  bus_sel_e              bus;
  alu_op_e               alu;
  logic [ADDR_WIDTH-1:0] rr_bits;
  logic                  unused_rr_bits;

  timing_decoder u_timing (
    .sc (sc),
    .t  (t)
  );

  assign rr_bits   = ir_data[ADDR_WIDTH-1:0];
  assign t_illegal = |t[15:7];

  // Only four register-reference bits are decoded here.
  assign unused_rr_bits = ^{rr_bits[10], rr_bits[8:6], rr_bits[4:1]};

  // Strobe decode: nothing is asserted while clear is high or once halted.
  always_comb begin
    ar_load   = 1'b0;
    ar_inc    = 1'b0;
    ar_clr    = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_clr    = 1'b0;
    dr_load   = 1'b0;
    dr_inc    = 1'b0;
    ac_load   = 1'b0;
    ac_inc    = 1'b0;
    ac_clr    = 1'b0;
    ir_load   = 1'b0;
    mem_write = 1'b0;
    bus       = BUS_NONE;
    alu       = ALU_NONE;
    hlt_now   = 1'b0;

    if (!clear && !halted_q) begin
      // Fetch
      if (t[0] && run) begin
        bus     = BUS_PC;
        ar_load = 1'b1;
      end
      if (t[1]) begin
        bus     = BUS_MEM;
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      if (t[2]) begin
        bus     = BUS_IR;
        ar_load = 1'b1;
      end

      // Indirect address fetch, or register-reference execution
      if (t[3]) begin
        if (op_q != OP_REG) begin
          if (ind_q) begin
            bus     = BUS_MEM;
            ar_load = 1'b1;
          end
        end else if (!ind_q) begin
          if (rr_bits[RR_CLA]) begin
            ac_clr = 1'b1;
          end else if (rr_bits[RR_CMA]) begin
            ac_load = 1'b1;
            alu     = ALU_CMA;
          end else if (rr_bits[RR_INC]) begin
            ac_inc = 1'b1;
          end else if (rr_bits[RR_HLT]) begin
            hlt_now = 1'b1;
          end
        end
      end

      // Memory-reference execution
      if (t[4]) begin
        case (op_q)
          OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
            bus     = BUS_MEM;
            dr_load = 1'b1;
          end
          OP_STA: begin
            bus       = BUS_AC;
            mem_write = 1'b1;
          end
          OP_BUN: begin
            bus     = BUS_AR;
            pc_load = 1'b1;
          end
          OP_BSA: begin
            bus       = BUS_PC;
            mem_write = 1'b1;
            ar_inc    = 1'b1;
          end
          default: ;
        endcase
      end
      if (t[5]) begin
        case (op_q)
          OP_AND: begin
            ac_load = 1'b1;
            alu     = ALU_AND;
          end
          OP_ADD: begin
            ac_load = 1'b1;
            alu     = ALU_ADD;
          end
          OP_LDA: begin
            ac_load = 1'b1;
            alu     = ALU_DR;
          end
          OP_BSA: begin
            bus     = BUS_AR;
            pc_load = 1'b1;
          end
          OP_ISZ: dr_inc = 1'b1;
          default: ;
        endcase
      end
      if (t[6] && op_q == OP_ISZ) begin
        bus       = BUS_DR;
        mem_write = 1'b1;
        pc_inc    = dr_zero;
      end
    end
  end

  // Sequence counter, latched opcode/I and halt flag
  always_ff @(posedge clock) begin
    if (clear) begin
      sc       <= 4'd0;
      halted_q <= 1'b0;
      op_q     <= OP_AND;
      ind_q    <= 1'b0;
    end else if (halted_q || t_illegal) begin
      sc <= 4'd0;
    end else begin
      if (t[0]) sc <= run ? 4'd1 : 4'd0;
      if (t[1]) sc <= 4'd2;
      if (t[2]) begin
        sc    <= 4'd3;
        op_q  <= opcode_e'(ir_data[IR_OP_MSB:IR_OP_LSB]);
        ind_q <= ir_data[IR_I_BIT];
      end
      if (t[3]) begin
        if (op_q == OP_REG) begin
          sc <= 4'd0;
          if (hlt_now) halted_q <= 1'b1;
        end else begin
          sc <= 4'd4;
        end
      end
      if (t[4]) begin
        if (op_q == OP_STA || op_q == OP_BUN || op_q == OP_REG) sc <= 4'd0;
        else                                                    sc <= 4'd5;
      end
      if (t[5]) sc <= (op_q == OP_ISZ) ? SC_LAST : 4'd0;
      if (t[6]) sc <= 4'd0;
    end
  end

  assign bus_sel  = bus;
  assign alu_op   = alu;
  assign sc_value = sc;
  assign halted   = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each stimulus cycle pushes the
// expected output vector; a negedge monitor pops and compares it.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic [15:0] ir_data;
  logic        dr_zero;
  logic        ar_load, ar_inc, ar_clr;
  logic        pc_load, pc_inc, pc_clr;
  logic        dr_load, dr_inc;
  logic        ac_load, ac_inc, ac_clr;
  logic        ir_load, mem_write;
  logic [2:0]  bus_sel, alu_op;
  logic [3:0]  sc_value;
  logic        halted;

  control_sequencer #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
    .clock     (clock),
    .clear     (clear),
    .run       (run),
    .ir_data   (ir_data),
    .dr_zero   (dr_zero),
    .ar_load   (ar_load),
    .ar_inc    (ar_inc),
    .ar_clr    (ar_clr),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .pc_clr    (pc_clr),
    .dr_load   (dr_load),
    .dr_inc    (dr_inc),
    .ac_load   (ac_load),
    .ac_inc    (ac_inc),
    .ac_clr    (ac_clr),
    .ir_load   (ir_load),
    .mem_write (mem_write),
    .bus_sel   (bus_sel),
    .alu_op    (alu_op),
    .sc_value  (sc_value),
    .halted    (halted)
  );

  always #5 clock = ~clock;

  // Strobe bit positions inside the 13-bit strobe field
  localparam logic [12:0] ARL = 13'h1000, ARI = 13'h0800, ARC = 13'h0400;
  localparam logic [12:0] PCL = 13'h0200, PCI = 13'h0100, PCC = 13'h0080;
  localparam logic [12:0] DRL = 13'h0040, DRI = 13'h0020;
  localparam logic [12:0] ACL = 13'h0010, ACI = 13'h0008, ACC = 13'h0004;
  localparam logic [12:0] IRL = 13'h0002, MW  = 13'h0001, NONE = 13'h0000;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [23:0] exp_q[$];

  logic [23:0] obs;
  assign obs = {ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr,
                dr_load, dr_inc, ac_load, ac_inc, ac_clr, ir_load, mem_write,
                bus_sel, alu_op, sc_value, halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] e(input logic [12:0] s, input logic [2:0] b,
                                    input logic [2:0] a, input logic [3:0] sc,
                                    input logic h);
    return {s, b, a, sc, h};
  endfunction

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      string       tg;
      logic [23:0] x;
      tg = tag_q.pop_front();
      x  = exp_q.pop_front();
      check(tg, {8'd0, obs}, {8'd0, x});
    end
  end

  // One clock cycle with the given inputs and the outputs expected in it
  task automatic step(input string tag, input logic clr, input logic rn,
                      input logic [15:0] ir, input logic dz, input logic [23:0] x);
    @(posedge clock);
    #1;
    clear   = clr;
    run     = rn;
    ir_data = ir;
    dr_zero = dz;
    tag_q.push_back(tag);
    exp_q.push_back(x);
  endtask

  task automatic fetch(input string tag, input logic [15:0] ir);
    step({tag, "_t0"}, 1'b0, 1'b1, ir, 1'b0, e(ARL,       3'd2, 3'd0, 4'd0, 1'b0));
    step({tag, "_t1"}, 1'b0, 1'b1, ir, 1'b0, e(IRL | PCI, 3'd7, 3'd0, 4'd1, 1'b0));
    step({tag, "_t2"}, 1'b0, 1'b1, ir, 1'b0, e(ARL,       3'd5, 3'd0, 4'd2, 1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    clear   = 1'b1;
    run     = 1'b0;
    ir_data = 16'h0000;
    dr_zero = 1'b0;

    // Reset and idle
    step("clr1", 1'b1, 1'b0, 16'h0, 1'b0, e(NONE, 3'd0, 3'd0, 4'd0, 1'b0));
    step("clr2", 1'b1, 1'b0, 16'h0, 1'b0, e(NONE, 3'd0, 3'd0, 4'd0, 1'b0));
    step("idle", 1'b0, 1'b0, 16'h0, 1'b0, e(NONE, 3'd0, 3'd0, 4'd0, 1'b0));

    // LDA direct
    fetch("lda", 16'h2005);
    step("lda_t3", 1'b0, 1'b1, 16'h2005, 1'b0, e(NONE, 3'd0, 3'd0, 4'd3, 1'b0));
    step("lda_t4", 1'b0, 1'b1, 16'h2005, 1'b0, e(DRL,  3'd7, 3'd0, 4'd4, 1'b0));
    step("lda_t5", 1'b0, 1'b1, 16'h2005, 1'b0, e(ACL,  3'd0, 3'd3, 4'd5, 1'b0));

    // ADD indirect
    fetch("add", 16'h9010);
    step("add_t3", 1'b0, 1'b1, 16'h9010, 1'b0, e(ARL, 3'd7, 3'd0, 4'd3, 1'b0));
    step("add_t4", 1'b0, 1'b1, 16'h9010, 1'b0, e(DRL, 3'd7, 3'd0, 4'd4, 1'b0));
    step("add_t5", 1'b0, 1'b1, 16'h9010, 1'b0, e(ACL, 3'd0, 3'd2, 4'd5, 1'b0));

    // AND direct
    fetch("and", 16'h0123);
    step("and_t3", 1'b0, 1'b1, 16'h0123, 1'b0, e(NONE, 3'd0, 3'd0, 4'd3, 1'b0));
    step("and_t4", 1'b0, 1'b1, 16'h0123, 1'b0, e(DRL,  3'd7, 3'd0, 4'd4, 1'b0));
    step("and_t5", 1'b0, 1'b1, 16'h0123, 1'b0, e(ACL,  3'd0, 3'd1, 4'd5, 1'b0));

    // ISZ, result zero then nonzero
    for (int k = 0; k < 2; k++) begin
      logic dz;
      dz = (k == 0);
      fetch("isz", 16'h6020);
      step("isz_t3", 1'b0, 1'b1, 16'h6020, 1'b0, e(NONE, 3'd0, 3'd0, 4'd3, 1'b0));
      step("isz_t4", 1'b0, 1'b1, 16'h6020, 1'b0, e(DRL,  3'd7, 3'd0, 4'd4, 1'b0));
      step("isz_t5", 1'b0, 1'b1, 16'h6020, 1'b0, e(DRI,  3'd0, 3'd0, 4'd5, 1'b0));
      step(dz ? "isz_t6_zero" : "isz_t6_nonzero", 1'b0, 1'b1, 16'h6020, dz,
           e(dz ? (MW | PCI) : MW, 3'd3, 3'd0, 4'd6, 1'b0));
    end

    // STA, BUN, BSA
    fetch("sta", 16'h3010);
    step("sta_t3", 1'b0, 1'b1, 16'h3010, 1'b0, e(NONE, 3'd0, 3'd0, 4'd3, 1'b0));
    step("sta_t4", 1'b0, 1'b1, 16'h3010, 1'b0, e(MW,   3'd4, 3'd0, 4'd4, 1'b0));
    fetch("bun", 16'h4020);
    step("bun_t3", 1'b0, 1'b1, 16'h4020, 1'b0, e(NONE, 3'd0, 3'd0, 4'd3, 1'b0));
    step("bun_t4", 1'b0, 1'b1, 16'h4020, 1'b0, e(PCL,  3'd1, 3'd0, 4'd4, 1'b0));
    fetch("bsa", 16'h5030);
    step("bsa_t3", 1'b0, 1'b1, 16'h5030, 1'b0, e(NONE,     3'd0, 3'd0, 4'd3, 1'b0));
    step("bsa_t4", 1'b0, 1'b1, 16'h5030, 1'b0, e(MW | ARI, 3'd2, 3'd0, 4'd4, 1'b0));
    step("bsa_t5", 1'b0, 1'b1, 16'h5030, 1'b0, e(PCL,      3'd1, 3'd0, 4'd5, 1'b0));

    // Register-reference priority and no-op cases
    fetch("cla", 16'h7801);
    step("cla_t3", 1'b0, 1'b1, 16'h7801, 1'b0, e(ACC,  3'd0, 3'd0, 4'd3, 1'b0));
    fetch("cma", 16'h7221);
    step("cma_t3", 1'b0, 1'b1, 16'h7221, 1'b0, e(ACL,  3'd0, 3'd4, 4'd3, 1'b0));
    fetch("inc", 16'h7021);
    step("inc_t3", 1'b0, 1'b1, 16'h7021, 1'b0, e(ACI,  3'd0, 3'd0, 4'd3, 1'b0));
    fetch("rr_ind", 16'hF801);
    step("rr_ind_t3", 1'b0, 1'b1, 16'hF801, 1'b0, e(NONE, 3'd0, 3'd0, 4'd3, 1'b0));
    fetch("rr_none", 16'h7000);
    step("rr_none_t3", 1'b0, 1'b0, 16'h7000, 1'b0, e(NONE, 3'd0, 3'd0, 4'd3, 1'b0));
    step("idle2", 1'b0, 1'b0, 16'h7000, 1'b0, e(NONE, 3'd0, 3'd0, 4'd0, 1'b0));

    // HLT, frozen while halted, clear resumes fetch
    fetch("hlt", 16'h7001);
    step("hlt_t3", 1'b0, 1'b1, 16'h7001, 1'b0, e(NONE, 3'd0, 3'd0, 4'd3, 1'b0));
    for (int k = 0; k < 10; k++)
      step("halted", 1'b0, 1'b1, 16'h2005, 1'b0, e(NONE, 3'd0, 3'd0, 4'd0, 1'b1));
    step("halt_clear", 1'b1, 1'b1, 16'h2005, 1'b0, e(NONE, 3'd0, 3'd0, 4'd0, 1'b1));
    fetch("resume", 16'h2005);
    step("resume_t3", 1'b0, 1'b1, 16'h2005, 1'b0, e(NONE, 3'd0, 3'd0, 4'd3, 1'b0));
    step("resume_t4", 1'b0, 1'b1, 16'h2005, 1'b0, e(DRL,  3'd7, 3'd0, 4'd4, 1'b0));
    step("resume_t5", 1'b0, 1'b1, 16'h2005, 1'b0, e(ACL,  3'd0, 3'd3, 4'd5, 1'b0));

    // Clear during BSA T4 suppresses the write and restarts the count
    fetch("bsa_clr", 16'h5030);
    step("bsa_clr_t3", 1'b0, 1'b1, 16'h5030, 1'b0, e(NONE, 3'd0, 3'd0, 4'd3, 1'b0));
    step("bsa_clr_t4", 1'b1, 1'b1, 16'h5030, 1'b0, e(NONE, 3'd0, 3'd0, 4'd4, 1'b0));
    step("bsa_clr_after", 1'b0, 1'b0, 16'h5030, 1'b0, e(NONE, 3'd0, 3'd0, 4'd0, 1'b0));

    repeat (2) @(posedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
